// File: rtl/iob_pcie_chnl_host_if.sv
// Host/user channel bundle: command and source/sink streams on the host side, RIFFA-style CHNL_* toward user logic.
// master = host/user environment, slave = the channel engine.
interface iob_pcie_chnl_host_if #(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64
);
    logic                        cmd_valid_i;
    logic                        cmd_ready_o;
    logic [DATA_W-1:0]           cmd_len_i;
    logic [DATA_W-2:0]           cmd_off_i;
    logic                        cmd_last_i;
    logic [C_PCI_DATA_WIDTH-1:0] src_data_i;
    logic                        src_valid_i;
    logic                        src_ready_o;

    logic                        CHNL_RX_o;
    logic                        CHNL_RX_LAST_o;
    logic [DATA_W-1:0]           CHNL_RX_LEN_o;
    logic [DATA_W-2:0]           CHNL_RX_OFF_o;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA_o;
    logic                        CHNL_RX_DATA_VALID_o;
    logic                        CHNL_RX_DATA_REN_i;
    logic                        CHNL_RX_ACK_i;

    logic                        CHNL_TX_i;
    logic                        CHNL_TX_LAST_i;
    logic [DATA_W-1:0]           CHNL_TX_LEN_i;
    logic [DATA_W-2:0]           CHNL_TX_OFF_i;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA_i;
    logic                        CHNL_TX_DATA_VALID_i;
    logic                        CHNL_TX_DATA_REN_o;
    logic                        CHNL_TX_ACK_o;

    logic [C_PCI_DATA_WIDTH-1:0] sink_data_o;
    logic                        sink_valid_o;
    logic                        sink_ready_i;
    logic [DATA_W-1:0]           tx_len_o;
    logic                        tx_last_o;
    logic                        tx_done_o;
    logic                        tx_err_o;

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_off_i, cmd_last_i, src_data_i, src_valid_i,
        output CHNL_RX_DATA_REN_i, CHNL_RX_ACK_i,
        output CHNL_TX_i, CHNL_TX_LAST_i, CHNL_TX_LEN_i, CHNL_TX_OFF_i,
        output CHNL_TX_DATA_i, CHNL_TX_DATA_VALID_i, sink_ready_i,
        input  cmd_ready_o, src_ready_o,
        input  CHNL_RX_o, CHNL_RX_LAST_o, CHNL_RX_LEN_o, CHNL_RX_OFF_o,
        input  CHNL_RX_DATA_o, CHNL_RX_DATA_VALID_o,
        input  CHNL_TX_DATA_REN_o, CHNL_TX_ACK_o,
        input  sink_data_o, sink_valid_o, tx_len_o, tx_last_o, tx_done_o, tx_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_off_i, cmd_last_i, src_data_i, src_valid_i,
        input  CHNL_RX_DATA_REN_i, CHNL_RX_ACK_i,
        input  CHNL_TX_i, CHNL_TX_LAST_i, CHNL_TX_LEN_i, CHNL_TX_OFF_i,
        input  CHNL_TX_DATA_i, CHNL_TX_DATA_VALID_i, sink_ready_i,
        output cmd_ready_o, src_ready_o,
        output CHNL_RX_o, CHNL_RX_LAST_o, CHNL_RX_LEN_o, CHNL_RX_OFF_o,
        output CHNL_RX_DATA_o, CHNL_RX_DATA_VALID_o,
        output CHNL_TX_DATA_REN_o, CHNL_TX_ACK_o,
        output sink_data_o, sink_valid_o, tx_len_o, tx_last_o, tx_done_o, tx_err_o
    );
endinterface

// File: rtl/iob_pcie_chnl_host.sv
// Host-side RIFFA channel model: independent RX (host->user) and TX (user->host) engines.
// Data beats pass through combinationally (zero latency); each side backpressures via REN / sink_ready.
module iob_pcie_chnl_host #(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iob_pcie_chnl_host_if.slave   bus
);
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA}       rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_DATA, T_WAIT_LOW}  tx_state_t;

    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO = '0;

    // (L+1)>>1 without an intermediate carry: L=all-ones yields 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] beats_of(input logic [DATA_W-1:0] len);
        return (len >> 1) + {{(DATA_W-1){1'b0}}, len[0]};
    endfunction

    rx_state_t         rx_state, rx_state_nxt;
    logic [DATA_W-1:0] rx_cnt, rx_cnt_nxt;
    logic              rx_latch;
    logic              rx_xfer;
    logic [DATA_W-1:0] rx_len;
    logic [DATA_W-2:0] rx_off;
    logic              rx_last;

    tx_state_t         tx_state, tx_state_nxt;
    logic [DATA_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [DATA_W-1:0] tx_beats;
    logic              tx_latch;
    logic              tx_xfer;
    logic [DATA_W-1:0] tx_len;
    logic              tx_last;
    logic              tx_ack, tx_ack_nxt;
    logic              tx_done, tx_done_nxt;
    logic              tx_err, tx_err_nxt;

    logic [C_PCI_DATA_WIDTH-1:0] rx_beat;
    logic [C_PCI_DATA_WIDTH-1:0] tx_beat;

    assign rx_beat = bus.src_data_i;
    assign tx_beat = bus.CHNL_TX_DATA_i;

    // ---------------- RX engine ----------------
    assign rx_xfer = (rx_state == R_DATA) && bus.src_valid_i && bus.CHNL_RX_DATA_REN_i;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_latch     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (bus.cmd_valid_i) begin
                    rx_latch     = 1'b1;
                    rx_cnt_nxt   = beats_of(bus.cmd_len_i);
                    rx_state_nxt = R_REQ;
                end
            end
            R_REQ: begin
                if (bus.CHNL_RX_ACK_i) begin
                    rx_state_nxt = (rx_cnt != ZERO) ? R_DATA : R_IDLE;
                end
            end
            R_DATA: begin
                if (rx_xfer) begin
                    if (rx_cnt == ONE) begin
                        rx_cnt_nxt   = ZERO;
                        rx_state_nxt = R_IDLE;
                    end else begin
                        rx_cnt_nxt = rx_cnt - ONE;
                    end
                end
            end
            default: begin
                rx_cnt_nxt   = ZERO;
                rx_state_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_cnt   <= ZERO;
            rx_len   <= ZERO;
            rx_off   <= '0;
            rx_last  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            if (rx_latch) begin
                rx_len  <= bus.cmd_len_i;
                rx_off  <= bus.cmd_off_i;
                rx_last <= bus.cmd_last_i;
            end
        end
    end

    assign bus.cmd_ready_o          = (rx_state == R_IDLE);
    assign bus.CHNL_RX_o            = (rx_state != R_IDLE);
    assign bus.CHNL_RX_LEN_o        = rx_len;
    assign bus.CHNL_RX_OFF_o        = rx_off;
    assign bus.CHNL_RX_LAST_o       = rx_last;
    assign bus.CHNL_RX_DATA_o       = rx_beat;
    assign bus.CHNL_RX_DATA_VALID_o = (rx_state == R_DATA) && bus.src_valid_i;
    assign bus.src_ready_o          = rx_xfer;

    // ---------------- TX engine ----------------
    assign tx_beats = beats_of(bus.CHNL_TX_LEN_i);
    assign tx_xfer  = (tx_state == T_DATA) && bus.CHNL_TX_DATA_VALID_i && bus.sink_ready_i;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_latch     = 1'b0;
        tx_ack_nxt   = 1'b0;
        tx_done_nxt  = 1'b0;
        tx_err_nxt   = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (bus.CHNL_TX_i) begin
                    tx_latch   = 1'b1;
                    tx_ack_nxt = 1'b1;
                    if (tx_beats != ZERO) begin
                        tx_cnt_nxt   = tx_beats;
                        tx_state_nxt = T_DATA;
                    end else begin
                        tx_done_nxt  = 1'b1;
                        tx_state_nxt = T_WAIT_LOW;
                    end
                end
            end
            T_DATA: begin
                // A final beat landing in the same cycle as TX dropping still completes.
                if (tx_xfer && tx_cnt == ONE) begin
                    tx_cnt_nxt   = ZERO;
                    tx_done_nxt  = 1'b1;
                    tx_state_nxt = T_WAIT_LOW;
                end else if (!bus.CHNL_TX_i) begin
                    tx_cnt_nxt   = ZERO;
                    tx_err_nxt   = 1'b1;
                    tx_state_nxt = T_IDLE;
                end else if (tx_xfer) begin
                    tx_cnt_nxt = tx_cnt - ONE;
                end
            end
            T_WAIT_LOW: begin
                if (!bus.CHNL_TX_i) begin
                    tx_state_nxt = T_IDLE;
                end
            end
            default: begin
                tx_cnt_nxt   = ZERO;
                tx_state_nxt = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= ZERO;
            tx_len   <= ZERO;
            tx_last  <= 1'b0;
            tx_ack   <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_ack   <= tx_ack_nxt;
            tx_done  <= tx_done_nxt;
            tx_err   <= tx_err_nxt;
            if (tx_latch) begin
                tx_len  <= bus.CHNL_TX_LEN_i;
                tx_last <= bus.CHNL_TX_LAST_i;
            end
        end
    end

    assign bus.sink_data_o        = tx_beat;
    assign bus.sink_valid_o       = (tx_state == T_DATA) && bus.CHNL_TX_DATA_VALID_i;
    assign bus.CHNL_TX_DATA_REN_o = (tx_state == T_DATA) && bus.sink_ready_i;
    assign bus.CHNL_TX_ACK_o      = tx_ack;
    assign bus.tx_len_o           = tx_len;
    assign bus.tx_last_o          = tx_last;
    assign bus.tx_done_o          = tx_done;
    assign bus.tx_err_o           = tx_err;

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Directed bench for iob_pcie_chnl_host: RX/TX transactions, backpressure, abort and mid-transaction reset.
module tb_iob_pcie_chnl_host;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    iob_pcie_chnl_host_if #(.DATA_W(32), .C_PCI_DATA_WIDTH(64)) bus ();

    iob_pcie_chnl_host #(.DATA_W(32), .C_PCI_DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid_i = 0; bus.cmd_len_i = 0; bus.cmd_off_i = 0; bus.cmd_last_i = 0;
        bus.src_data_i = 0; bus.src_valid_i = 0; bus.CHNL_RX_DATA_REN_i = 0; bus.CHNL_RX_ACK_i = 0;
        bus.CHNL_TX_i = 0; bus.CHNL_TX_LAST_i = 0; bus.CHNL_TX_LEN_i = 0; bus.CHNL_TX_OFF_i = 0;
        bus.CHNL_TX_DATA_i = 0; bus.CHNL_TX_DATA_VALID_i = 0; bus.sink_ready_i = 0;
    endtask

    // Stimulus-only: RX command with immediate ACK and REN held high; counts transferred beats.
    task automatic run_rx(input logic [31:0] len, output int beats);
        bus.cmd_len_i = len; bus.cmd_valid_i = 1; step();
        bus.cmd_valid_i = 0; bus.CHNL_RX_ACK_i = 1; step();
        bus.CHNL_RX_ACK_i = 0; bus.src_valid_i = 1; bus.CHNL_RX_DATA_REN_i = 1;
        beats = 0;
        for (int c = 0; c < 40 && bus.CHNL_RX_o; c++) begin
            #1; if (bus.src_ready_o) beats++;
            step();
        end
        bus.src_valid_i = 0; bus.CHNL_RX_DATA_REN_i = 0;
    endtask

    // Stimulus-only: TX request held for a fixed window with sink always ready.
    task automatic run_tx(input logic [31:0] len, input int cycles,
                          output int acks, output int beats, output int dones, output int errs);
        acks = 0; beats = 0; dones = 0; errs = 0;
        bus.CHNL_TX_i = 1; bus.CHNL_TX_LEN_i = len; bus.CHNL_TX_DATA_VALID_i = 1; bus.sink_ready_i = 1;
        for (int c = 0; c < cycles; c++) begin
            acks += int'(bus.CHNL_TX_ACK_o); dones += int'(bus.tx_done_o); errs += int'(bus.tx_err_o);
            #1; if (bus.sink_valid_o && bus.sink_ready_i) beats++;
            step();
        end
        bus.CHNL_TX_i = 0; bus.CHNL_TX_DATA_VALID_i = 0; bus.sink_ready_i = 0;
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        repeat (2) @(posedge clk); #1;
        tests++; if (bus.CHNL_RX_o !== 1'b0) begin fails++; $display("FAIL reset_chnl_rx: got %b want 0", bus.CHNL_RX_o); end
        tests++; if (bus.CHNL_RX_LEN_o !== 32'd0) begin fails++; $display("FAIL reset_rx_len: got %0d want 0", bus.CHNL_RX_LEN_o); end
        tests++; if (bus.CHNL_TX_ACK_o !== 1'b0) begin fails++; $display("FAIL reset_tx_ack: got %b want 0", bus.CHNL_TX_ACK_o); end
        tests++; if ({bus.tx_done_o, bus.tx_err_o} !== 2'b00) begin fails++; $display("FAIL reset_done_err: got %b want 00", {bus.tx_done_o, bus.tx_err_o}); end
        tests++; if (bus.tx_len_o !== 32'd0) begin fails++; $display("FAIL reset_tx_len: got %0d want 0", bus.tx_len_o); end
        rst_n = 1; step();
        tests++; if (bus.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready_o); end
    endtask

    task automatic test_rx_len8();
        int n = 0;
        bus.cmd_len_i = 8; bus.cmd_off_i = 3; bus.cmd_last_i = 1; bus.cmd_valid_i = 1; #1;
        tests++; if (bus.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL rx8_cmd_ready: got %b want 1", bus.cmd_ready_o); end
        step(); bus.cmd_valid_i = 0; bus.cmd_last_i = 0;
        tests++; if (bus.CHNL_RX_o !== 1'b1) begin fails++; $display("FAIL rx8_rx_active: got %b want 1", bus.CHNL_RX_o); end
        tests++; if ({bus.CHNL_RX_LEN_o, bus.CHNL_RX_OFF_o, bus.CHNL_RX_LAST_o} !== {32'd8, 31'd3, 1'b1})
            begin fails++; $display("FAIL rx8_latched: got len=%0d off=%0d last=%b want 8 3 1", bus.CHNL_RX_LEN_o, bus.CHNL_RX_OFF_o, bus.CHNL_RX_LAST_o); end
        tests++; if (bus.cmd_ready_o !== 1'b0) begin fails++; $display("FAIL rx8_cmd_busy: got %b want 0", bus.cmd_ready_o); end
        step(); step();
        tests++; if (bus.CHNL_RX_o !== 1'b1) begin fails++; $display("FAIL rx8_wait_ack: got %b want 1", bus.CHNL_RX_o); end
        bus.CHNL_RX_ACK_i = 1; step(); bus.CHNL_RX_ACK_i = 0;
        bus.src_valid_i = 1; bus.CHNL_RX_DATA_REN_i = 1;
        for (int c = 0; c < 20 && bus.CHNL_RX_o; c++) begin
            bus.src_data_i = 64'hA000 + 64'(n); #1;
            if (bus.src_ready_o) begin
                tests++; if (bus.CHNL_RX_DATA_o !== 64'hA000 + 64'(n)) begin fails++; $display("FAIL rx8_data: got %h want %h", bus.CHNL_RX_DATA_o, 64'hA000 + 64'(n)); end
                n++;
            end
            step();
        end
        tests++; if (n !== 4) begin fails++; $display("FAIL rx8_beats: got %0d want 4", n); end
        tests++; if (bus.CHNL_RX_o !== 1'b0) begin fails++; $display("FAIL rx8_done: got %b want 0", bus.CHNL_RX_o); end
        bus.src_valid_i = 0; bus.CHNL_RX_DATA_REN_i = 0;
    endtask

    task automatic test_rx_len5_toggle();
        int n = 0;
        bus.cmd_len_i = 5; bus.cmd_valid_i = 1; step();
        bus.cmd_valid_i = 0; bus.CHNL_RX_ACK_i = 1; step();
        bus.CHNL_RX_ACK_i = 0; bus.src_valid_i = 1;
        for (int c = 0; c < 20 && bus.CHNL_RX_o; c++) begin
            bus.CHNL_RX_DATA_REN_i = (c % 2 == 0);
            bus.src_data_i = 64'hC000 + 64'(n); #1;
            tests++; if (bus.src_ready_o !== bus.CHNL_RX_DATA_REN_i) begin fails++; $display("FAIL rx5_ready c=%0d: got %b want %b", c, bus.src_ready_o, bus.CHNL_RX_DATA_REN_i); end
            if (bus.src_ready_o) begin
                tests++; if (bus.CHNL_RX_DATA_o !== 64'hC000 + 64'(n)) begin fails++; $display("FAIL rx5_data: got %h want %h", bus.CHNL_RX_DATA_o, 64'hC000 + 64'(n)); end
                n++;
            end
            step();
        end
        tests++; if (n !== 3) begin fails++; $display("FAIL rx5_beats: got %0d want 3", n); end
        bus.src_valid_i = 0; bus.CHNL_RX_DATA_REN_i = 0;
    endtask

    task automatic test_rx_len0();
        bus.CHNL_RX_ACK_i = 1; step(); bus.CHNL_RX_ACK_i = 0;
        tests++; if (bus.CHNL_RX_o !== 1'b0) begin fails++; $display("FAIL rx0_stray_ack: got %b want 0", bus.CHNL_RX_o); end
        bus.cmd_len_i = 0; bus.cmd_valid_i = 1; step();
        bus.cmd_valid_i = 0; bus.src_valid_i = 1; bus.CHNL_RX_DATA_REN_i = 1; #1;
        tests++; if (bus.CHNL_RX_DATA_VALID_o !== 1'b0) begin fails++; $display("FAIL rx0_valid_req: got %b want 0", bus.CHNL_RX_DATA_VALID_o); end
        bus.CHNL_RX_ACK_i = 1; step(); bus.CHNL_RX_ACK_i = 0; #1;
        tests++; if ({bus.CHNL_RX_o, bus.cmd_ready_o, bus.CHNL_RX_DATA_VALID_o, bus.src_ready_o} !== 4'b0100)
            begin fails++; $display("FAIL rx0_idle: got %b want 0100", {bus.CHNL_RX_o, bus.cmd_ready_o, bus.CHNL_RX_DATA_VALID_o, bus.src_ready_o}); end
        bus.src_valid_i = 0; bus.CHNL_RX_DATA_REN_i = 0;
    endtask

    task automatic test_tx_len6();
        int acks = 0, dones = 0, errs = 0, n = 0;
        bus.CHNL_TX_i = 1; bus.CHNL_TX_LEN_i = 6; bus.CHNL_TX_LAST_i = 1; bus.CHNL_TX_DATA_VALID_i = 1;
        for (int c = 0; c < 30; c++) begin
            acks += int'(bus.CHNL_TX_ACK_o); dones += int'(bus.tx_done_o); errs += int'(bus.tx_err_o);
            bus.sink_ready_i = (c % 3 == 2);
            bus.CHNL_TX_DATA_i = 64'hB000 + 64'(n); #1;
            if (bus.sink_valid_o && bus.sink_ready_i) begin
                tests++; if ({bus.sink_data_o, bus.CHNL_TX_DATA_REN_o} !== {64'hB000 + 64'(n), 1'b1})
                    begin fails++; $display("FAIL tx6_beat: got %h ren=%b want %h ren=1", bus.sink_data_o, bus.CHNL_TX_DATA_REN_o, 64'hB000 + 64'(n)); end
                n++;
            end
            step();
        end
        tests++; if (acks !== 1) begin fails++; $display("FAIL tx6_acks: got %0d want 1", acks); end
        tests++; if (n !== 3) begin fails++; $display("FAIL tx6_beats: got %0d want 3", n); end
        tests++; if ({dones, errs} !== {32'd1, 32'd0}) begin fails++; $display("FAIL tx6_done_err: got %0d/%0d want 1/0", dones, errs); end
        tests++; if ({bus.tx_len_o, bus.tx_last_o} !== {32'd6, 1'b1}) begin fails++; $display("FAIL tx6_latched: got %0d/%b want 6/1", bus.tx_len_o, bus.tx_last_o); end
        bus.CHNL_TX_i = 0; bus.CHNL_TX_LAST_i = 0; bus.CHNL_TX_DATA_VALID_i = 0; bus.sink_ready_i = 0;
        step(); step();
    endtask

    task automatic test_tx_abort();
        int acks = 0, dones = 0, errs = 0, n = 0;
        bus.CHNL_TX_i = 1; bus.CHNL_TX_LEN_i = 8; bus.CHNL_TX_DATA_VALID_i = 1; bus.sink_ready_i = 1;
        for (int c = 0; c < 8; c++) begin
            acks += int'(bus.CHNL_TX_ACK_o); dones += int'(bus.tx_done_o); errs += int'(bus.tx_err_o);
            if (c == 2) begin bus.CHNL_TX_i = 0; bus.sink_ready_i = 0; end
            #1; if (bus.sink_valid_o && bus.sink_ready_i) n++;
            step();
        end
        tests++; if (n !== 1) begin fails++; $display("FAIL abort_beats: got %0d want 1", n); end
        tests++; if (errs !== 1) begin fails++; $display("FAIL abort_err: got %0d want 1", errs); end
        tests++; if ({acks, dones} !== {32'd1, 32'd0}) begin fails++; $display("FAIL abort_ack_done: got %0d/%0d want 1/0", acks, dones); end
        bus.CHNL_TX_DATA_VALID_i = 0;
        run_tx(32'd2, 6, acks, n, dones, errs);
        tests++; if ({acks, n, dones, errs} !== {32'd1, 32'd1, 32'd1, 32'd0})
            begin fails++; $display("FAIL abort_retry: got ack=%0d beats=%0d done=%0d err=%0d want 1 1 1 0", acks, n, dones, errs); end
    endtask

    task automatic test_tx_len0();
        int acks, n, dones, errs;
        run_tx(32'd0, 5, acks, n, dones, errs);
        tests++; if ({acks, n, dones, errs} !== {32'd1, 32'd0, 32'd1, 32'd0})
            begin fails++; $display("FAIL tx0: got ack=%0d beats=%0d done=%0d err=%0d want 1 0 1 0", acks, n, dones, errs); end
    endtask

    task automatic test_concurrent();
        int rxn = 0, txn = 0, dones = 0, tx_first = -1, rx_last = -1;
        bus.cmd_len_i = 4; bus.cmd_valid_i = 1; bus.CHNL_RX_ACK_i = 1;
        bus.src_valid_i = 1; bus.CHNL_RX_DATA_REN_i = 1;
        bus.CHNL_TX_i = 1; bus.CHNL_TX_LEN_i = 4; bus.CHNL_TX_DATA_VALID_i = 1; bus.sink_ready_i = 1;
        for (int c = 0; c < 8; c++) begin
            dones += int'(bus.tx_done_o);
            if (c == 1) bus.cmd_valid_i = 0;
            #1;
            if (bus.src_ready_o) begin rxn++; rx_last = c; end
            if (bus.sink_valid_o && bus.sink_ready_i) begin txn++; if (tx_first < 0) tx_first = c; end
            step();
        end
        tests++; if ({rxn, txn, dones} !== {32'd2, 32'd2, 32'd1}) begin fails++; $display("FAIL conc_counts: got rx=%0d tx=%0d done=%0d want 2 2 1", rxn, txn, dones); end
        tests++; if ({tx_first, rx_last} !== {32'd1, 32'd3}) begin fails++; $display("FAIL conc_timing: got tx_first=%0d rx_last=%0d want 1 3", tx_first, rx_last); end
        idle_inputs(); step(); step();
    endtask

    task automatic test_reset_mid();
        int n, acks, dones, errs;
        bus.cmd_len_i = 32'hFFFF_FFFF; bus.cmd_off_i = 31'h55; bus.cmd_valid_i = 1; step();
        bus.cmd_valid_i = 0; bus.CHNL_RX_ACK_i = 1; step();
        bus.CHNL_RX_ACK_i = 0; bus.src_valid_i = 1; bus.CHNL_RX_DATA_REN_i = 1;
        bus.CHNL_TX_i = 1; bus.CHNL_TX_LEN_i = 8; bus.CHNL_TX_LAST_i = 1; bus.CHNL_TX_DATA_VALID_i = 1; bus.sink_ready_i = 1;
        step(); step(); step();
        tests++; if ({bus.CHNL_RX_DATA_VALID_o, bus.sink_valid_o} !== 2'b11) begin fails++; $display("FAIL mid_active: got %b want 11", {bus.CHNL_RX_DATA_VALID_o, bus.sink_valid_o}); end
        #2 rst_n = 0; #1;
        tests++; if ({bus.CHNL_RX_o, bus.CHNL_RX_LAST_o, bus.CHNL_RX_DATA_VALID_o, bus.src_ready_o, bus.sink_valid_o,
                      bus.CHNL_TX_DATA_REN_o, bus.CHNL_TX_ACK_o, bus.tx_last_o, bus.tx_done_o, bus.tx_err_o} !== 10'b0)
            begin fails++; $display("FAIL mid_reset_flags: some output still high"); end
        tests++; if ({bus.CHNL_RX_LEN_o, bus.CHNL_RX_OFF_o, bus.tx_len_o} !== 95'd0)
            begin fails++; $display("FAIL mid_reset_fields: got len=%0d off=%0d txlen=%0d want 0", bus.CHNL_RX_LEN_o, bus.CHNL_RX_OFF_o, bus.tx_len_o); end
        idle_inputs(); step(); rst_n = 1; step();
        run_rx(32'd3, n);
        tests++; if (n !== 2) begin fails++; $display("FAIL mid_rx_after: got %0d want 2", n); end
        run_tx(32'd3, 6, acks, n, dones, errs);
        tests++; if ({acks, n, dones, errs} !== {32'd1, 32'd2, 32'd1, 32'd0})
            begin fails++; $display("FAIL mid_tx_after: got ack=%0d beats=%0d done=%0d err=%0d want 1 2 1 0", acks, n, dones, errs); end
    endtask

    initial begin
        test_reset();
        test_rx_len8();
        test_rx_len5_toggle();
        test_rx_len0();
        test_tx_len6();
        test_tx_abort();
        test_tx_len0();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
